// File: rtl/hex_display_pkg.sv
// Shared types and constants for the seven-segment hex display block.
package hex_display_pkg;

   typedef enum logic [1:0] {IDLE, STATIC, SCROLL} disp_state_e;

   localparam logic [6:0] SEG_BLANK   = 7'h7F;
   localparam int         NUM_DIGITS  = 6;
   localparam int         NUM_NIBBLES = 8;

   // Symbols in the scroll ring: every nibble followed by the blank gap.
   function automatic int ring_len(input int gap_blanks);
      return NUM_NIBBLES + gap_blanks;
   endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Nibble to active-low seven-segment pattern (bit6 = g .. bit0 = a), with blank override.
module hex7seg_decoder
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
         endcase
      end
   end

endmodule

// File: rtl/hex_scroll_display.sv
// Shows a 32-bit register value on six hex digits, either the static low 24 bits
// or a marquee of all eight nibbles plus a blank gap; restarts on any value change.
module hex_scroll_display
   import hex_display_pkg::*;
#(
   parameter int TICK_DIV   = 12500000,
   parameter int GAP_BLANKS = 2
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] Q_in,
   input  logic        enable,
   input  logic        mode,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX4,
   output logic [6:0]  HEX5,
   output logic        wrap_pulse
);

   localparam int RING = ring_len(GAP_BLANKS);
   localparam int PW   = $clog2(RING);
   localparam int SW   = $clog2(RING + NUM_DIGITS);
   localparam int TW   = $clog2(TICK_DIV);

   localparam logic [PW-1:0] PTR_LAST  = PW'(RING - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   disp_state_e                         state, target;
   logic [31:0]                         snap;
   logic [NUM_NIBBLES-1:0][3:0]         snap_nib;
   logic [PW-1:0]                       ptr;
   logic [TW-1:0]                       tick_cnt;
   logic [NUM_DIGITS-1:0][6:0]          seg_next, hex_q;

   assign snap_nib = snap;

   always_comb begin
      target = IDLE;
      if (enable) target = mode ? SCROLL : STATIC;
   end

   // HEX5 is the leftmost digit and shows ring symbol ptr; HEXi shows ptr+5-i.
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      logic [SW-1:0] sum, k;
      logic [3:0]    nib;
      logic          blank;

      always_comb begin
         sum   = SW'(ptr) + SW'(NUM_DIGITS - 1 - i);
         k     = (sum >= SW'(RING)) ? sum - SW'(RING) : sum;
         nib   = 4'h0;
         blank = 1'b1;
         case (state)
            STATIC: begin
               nib   = snap[4*i +: 4];
               blank = 1'b0;
            end
            SCROLL: begin
               if (k < SW'(NUM_NIBBLES)) begin
                  nib   = snap_nib[3'(NUM_NIBBLES - 1) - k[2:0]];
                  blank = 1'b0;
               end
            end
            default: ;
         endcase
      end

      hex7seg_decoder u_dec (
         .nibble (nib),
         .blank  (blank),
         .seg    (seg_next[i])
      );
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= IDLE;
         snap       <= '0;
         ptr        <= '0;
         tick_cnt   <= '0;
         wrap_pulse <= 1'b0;
         hex_q      <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         state      <= target;
         wrap_pulse <= 1'b0;
         hex_q      <= seg_next;
         // A value change outranks a scroll tick landing on the same edge.
         if (Q_in != snap) begin
            snap     <= Q_in;
            ptr      <= '0;
            tick_cnt <= '0;
         end else if (target != state || state != SCROLL) begin
            ptr      <= '0;
            tick_cnt <= '0;
         end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (ptr == PTR_LAST) begin
               ptr        <= '0;
               wrap_pulse <= 1'b1;
            end else begin
               ptr <= ptr + PW'(1);
            end
         end else begin
            tick_cnt <= tick_cnt + TW'(1);
         end
      end
   end

   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
   assign HEX4 = hex_q[4];
   assign HEX5 = hex_q[5];

endmodule
